// File: rtl/bt_cmd_pkg.sv
// Shared constants, parser state type and opcode decode for the cart command controller.
package bt_cmd_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hAA;

  localparam logic [7:0] OP_F = 8'h46;
  localparam logic [7:0] OP_B = 8'h42;
  localparam logic [7:0] OP_L = 8'h4C;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_S = 8'h53;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;

  typedef enum logic [1:0] {
    WAIT_HDR,
    GET_CMD,
    GET_ARG,
    GET_CHK
  } parse_state_t;

  typedef struct packed {
    logic       known;
    logic [1:0] left;
    logic [1:0] right;
    logic       stop;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [7:0] op);
    op_dec_t d;
    d.known = 1'b1;
    d.left  = DIR_STOP;
    d.right = DIR_STOP;
    d.stop  = 1'b0;
    case (op)
      OP_F: begin d.left = DIR_FWD; d.right = DIR_FWD; end
      OP_B: begin d.left = DIR_REV; d.right = DIR_REV; end
      OP_L: begin d.left = DIR_REV; d.right = DIR_FWD; end
      OP_R: begin d.left = DIR_FWD; d.right = DIR_REV; end
      OP_S: d.stop = 1'b1;
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Saturating link watchdog: counts cycles since the last accepted frame and
// flags expiry once WDT_CYCLES is reached. A kick always wins over expiry.
module cmd_watchdog #(
  parameter int unsigned WDT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expire_now,
  output logic expired
);

  localparam int unsigned CW = $clog2(WDT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WDT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(WDT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // High in the cycle whose closing edge makes the count reach LIMIT.
  assign expire_now = !kick && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (kick) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      if (cnt != LIMIT) cnt <= cnt + 1'b1;
      if (expire_now) expired <= 1'b1;
    end
  end

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Parses UART bytes into AA/CMD/ARG/CHK frames and drives the cart motor outputs,
// with an inter-byte timeout and a link watchdog that forces a stop.
//
// state    | meaning
// WAIT_HDR | idle, dropping bytes until 0xAA
// GET_CMD  | next byte is the opcode
// GET_ARG  | next byte is the speed argument
// GET_CHK  | next byte is CMD^ARG; frame applied or rejected
module bt_cmd_ctrl
  import bt_cmd_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 208_320,
  parameter int unsigned WDT_CYCLES   = 50_000_000,
  parameter logic [7:0]  SPEED_MAX    = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [1:0] left_dir,
  output logic [1:0] right_dir,
  output logic [7:0] speed,
  output logic       cmd_strobe,
  output logic       frame_err,
  output logic       wdt_expired
);

  localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_TIMEOUT - 1);

  parse_state_t  state;
  logic [7:0]    cmd;
  logic [7:0]    arg;
  logic [BW-1:0] byte_cnt;

  op_dec_t    dec;
  logic       accept;
  logic       byte_timeout;
  logic [7:0] arg_speed;
  logic       expire_now;
  logic       expired;

  assign dec          = decode_op(cmd);
  assign accept       = rx_valid && (state == GET_CHK) && (rx_byte == (cmd ^ arg)) && dec.known;
  // A byte arriving in the timeout cycle takes priority over the timeout.
  assign byte_timeout = !rx_valid && (state != WAIT_HDR) && (byte_cnt == BYTE_LAST);
  assign arg_speed    = (arg > SPEED_MAX) ? SPEED_MAX : arg;

  cmd_watchdog #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .kick      (accept),
    .expire_now(expire_now),
    .expired   (expired)
  );

  assign wdt_expired = expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_HDR;
      cmd        <= '0;
      arg        <= '0;
      byte_cnt   <= '0;
      left_dir   <= DIR_STOP;
      right_dir  <= DIR_STOP;
      speed      <= '0;
      cmd_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      frame_err  <= 1'b0;

      if (rx_valid || state == WAIT_HDR) byte_cnt <= '0;
      else                               byte_cnt <= byte_cnt + 1'b1;

      if (rx_valid) begin
        case (state)
          WAIT_HDR: if (rx_byte == HDR_BYTE) state <= GET_CMD;
          GET_CMD: begin
            cmd   <= rx_byte;
            state <= GET_ARG;
          end
          GET_ARG: begin
            arg   <= rx_byte;
            state <= GET_CHK;
          end
          GET_CHK: begin
            state <= WAIT_HDR;
            if (accept) begin
              left_dir   <= dec.left;
              right_dir  <= dec.right;
              speed      <= dec.stop ? 8'd0 : arg_speed;
              cmd_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= WAIT_HDR;
        endcase
      end else if (byte_timeout) begin
        frame_err <= 1'b1;
        state     <= WAIT_HDR;
      end

      // expire_now is already masked by an accepted frame, so this never clobbers one.
      if (expire_now) begin
        left_dir  <= DIR_STOP;
        right_dir <= DIR_STOP;
        speed     <= '0;
      end
    end
  end

endmodule
